// File: rtl/keyed_lock_pipe.sv
// -----------------------------------------------------------------------------
// keyed_lock_pipe
//
// Keyed data transform behind a serial key lock. The key is shifted in LSB
// first. Once all KEY_W bits have arrived, the block unlocks. While unlocked it
// accepts operands through a valid/ready pipeline of PIPE register stages.
//
// Transform (computed at the input):
//   x  = in_data ^ kin
//   x' = x with bit0 replaced by lut[{x[1],x[0]}]
//   y  = x' ^ kout
// Key layout: kin = key[DATA_W-1:0], kout = key[2*DATA_W-1:DATA_W],
//             lut = key[KEY_W-1:KEY_W-4]
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          synchronous active-low reset
//   key_start      clears the key, flushes the pipeline, starts a key load
//   key_bit        serial key data
//   key_bit_valid  key_bit qualifier (honoured only while loading)
//   in_valid       input operand valid
//   in_data        plaintext operand
//   in_ready       input accepted when in_valid && in_ready
//   out_valid      output valid
//   out_data       keyed result (0 whenever out_valid is low)
//   out_ready      downstream accept
//   unlocked       high only while the full key is loaded
//   key_cnt        number of key bits loaded so far
// -----------------------------------------------------------------------------
module keyed_lock_pipe #(
    parameter  int DATA_W = 8,
    parameter  int PIPE   = 2,
    localparam int KEY_W  = 2*DATA_W + 4,
    localparam int CNT_W  = $clog2(KEY_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_bit,
    input  logic              key_bit_valid,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              unlocked,
    output logic [CNT_W-1:0]  key_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);

    logic [1:0]        state;
    logic [KEY_W-1:0]  key;

    logic [DATA_W-1:0] kin;
    logic [DATA_W-1:0] kout;
    logic [3:0]        lut;

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] x_sub;
    logic [DATA_W-1:0] result;

    logic [PIPE-1:0]   stage_valid;
    logic [DATA_W-1:0] stage_data [PIPE];

    logic              advance;

    assign kin  = key[DATA_W-1:0];
    assign kout = key[2*DATA_W-1:DATA_W];
    assign lut  = key[KEY_W-1:KEY_W-4];

    // Keyed transform on the incoming operand.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every variable
        // is assigned on every pass, so no latch is inferred.
        x        = in_data ^ kin;
        x_sub    = x;
        x_sub[0] = lut[x[1:0]];
        result   = x_sub ^ kout;
    end

    // All stages move together. A bubble at the output never blocks the stages behind it.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = (state == ACTIVE) & advance;
    assign unlocked  = (state == ACTIVE);
    assign out_valid = stage_valid[PIPE-1];
    assign out_data  = stage_valid[PIPE-1] ? stage_data[PIPE-1] : '0;

    // Lock FSM and serial key register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state   <= IDLE;
            key     <= '0;
            key_cnt <= '0;
        end else if (key_start) begin
            // key_start beats a coincident key bit, so that bit is dropped.
            state   <= LOAD;
            key     <= '0;
            key_cnt <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (key_bit_valid) begin
                        key[key_cnt] <= key_bit;
                        key_cnt      <= key_cnt + CNT_W'(1);
                        if (key_cnt == KEY_LAST) begin
                            state <= ACTIVE;
                        end
                    end
                end
                IDLE, ACTIVE: ;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath pipeline. key_start drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid <= '0;
            // NOTE: the data stages are cleared on reset as well. The output is
            // masked by valid, but this keeps any old plaintext-derived value
            // from staying in the block after a reset.
            for (int i = 0; i < PIPE; i++) begin
                stage_data[i] <= '0;
            end
        end else if (key_start) begin
            stage_valid <= '0;
        end else if (advance) begin
            stage_valid[0] <= in_valid & in_ready;
            stage_data[0]  <= result;
            for (int i = 1; i < PIPE; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

endmodule

// File: tb/tb_keyed_lock_pipe.sv
// -----------------------------------------------------------------------------
// tb_keyed_lock_pipe
//
// Self-checking bench for keyed_lock_pipe (DATA_W=8, PIPE=2). A reference model
// tracks the lock and key load count. It keeps a queue of expected results,
// computed with integer arithmetic from the key fields. Every clock step checks
// in_ready, unlocked, key_cnt, output zeroing, output stability during a stall
// and output ordering. Directed steps add explicit checks on top of these.
// -----------------------------------------------------------------------------
module tb_keyed_lock_pipe;

    localparam int DW    = 8;
    localparam int PIPE  = 2;
    localparam int KEY_W = 2*DW + 4;
    localparam int CNT_W = $clog2(KEY_W + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              key_start;
    logic              key_bit;
    logic              key_bit_valid;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic              unlocked;
    logic [CNT_W-1:0]  key_cnt;

    keyed_lock_pipe #(.DATA_W(DW), .PIPE(PIPE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_start     (key_start),
        .key_bit       (key_bit),
        .key_bit_valid (key_bit_valid),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .unlocked      (unlocked),
        .key_cnt       (key_cnt)
    );

    always #5 clk = ~clk;

    // Bookkeeping
    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    bit             m_known   = 0;
    bit             m_active  = 0;
    bit             m_loading = 0;
    int             m_cnt     = 0;
    logic [KEY_W-1:0] m_key   = '0;
    logic [DW-1:0]  exp_q[$];
    int             n_out     = 0;
    bit             last_fin  = 0;
    bit             prev_stall = 0;
    logic [DW-1:0]  prev_data = '0;

    localparam logic [KEY_W-1:0] GOLD = {4'b0110, 8'hFF, 8'h0F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected result from the key fields, using plain integer arithmetic.
    function automatic logic [DW-1:0] xform(input logic [DW-1:0] d, input logic [KEY_W-1:0] k);
        int mask, kin, kout, lut, x, b, y;
        mask = (1 << DW) - 1;
        kin  = int'(k) & mask;
        kout = (int'(k) >> DW) & mask;
        lut  = (int'(k) >> (2*DW)) & 15;
        x    = int'(d) ^ kin;
        b    = (lut >> (x % 4)) & 1;
        y    = ((x & ~1) | b) ^ kout;
        return DW'(y & mask);
    endfunction

    // One clock cycle: check the current outputs, advance the model at the edge,
    // and return 1 time unit after the edge so the caller can drive new inputs.
    task automatic tick();
        bit exp_rdy, fin;
        #1;
        exp_rdy = m_active && (!out_valid || out_ready);
        fin     = exp_rdy && in_valid;
        if (m_known) begin
            check("in_ready", in_ready, exp_rdy);
            check("unlocked", unlocked, m_active);
            check("key_cnt", key_cnt, m_cnt);
            if (!out_valid) check("out_zero", out_data, 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else if (out_ready) begin
                    check("out_data", out_data, exp_q.pop_front());
                    n_out++;
                end else begin
                    check("stalled_head", out_data, exp_q[0]);
                end
            end
        end
        prev_stall = out_valid && !out_ready && rst_n && !key_start;
        prev_data  = out_data;
        last_fin   = fin && rst_n && !key_start;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_known = 1; m_active = 0; m_loading = 0; m_cnt = 0; m_key = '0;
        end else if (key_start) begin
            exp_q.delete();
            m_active = 0; m_loading = 1; m_cnt = 0; m_key = '0;
        end else begin
            if (fin) exp_q.push_back(xform(in_data, m_key));
            if (m_loading && key_bit_valid) begin
                m_key[m_cnt] = key_bit;
                m_cnt++;
                if (m_cnt == KEY_W) begin
                    m_loading = 0;
                    m_active  = 1;
                end
            end
        end
        #1;
    endtask

    task automatic load_key(input logic [KEY_W-1:0] k, input int nbits);
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                key_bit_valid = 1'b0;
                key_bit       = 1'($urandom);
                tick();
            end
            key_bit       = k[i];
            key_bit_valid = 1'b1;
            tick();
        end
        key_bit_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < PIPE + 2; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        int d;
        logic [KEY_W-1:0] rkey;

        rst_n = 1'b0; key_start = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_unlocked", unlocked, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_key_cnt", key_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Golden key and a single item, with an explicit latency check
        load_key(GOLD, KEY_W - 1);
        check("gold_pre_unlock", unlocked, 0);
        key_bit = GOLD[KEY_W-1]; key_bit_valid = 1'b1;
        tick();
        key_bit_valid = 1'b0;
        check("gold_unlocked", unlocked, 1);
        check("gold_key_cnt", key_cnt, KEY_W);
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 8'h54);
        drain();

        // 8 items in order, with a 3-cycle output stall in the middle
        n0 = n_out;
        d  = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid  = (d < 8);
            in_data   = DW'(d);
            out_ready = !(c >= 4 && c < 7);
            tick();
            if (last_fin) d++;
        end
        drain();
        check("seq_count", n_out - n0, 8);

        // key_start with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C; tick();
        in_data   = 8'hC3; tick();
        check("flight_valid", out_valid, 1);
        in_valid  = 1'b0;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        check("ks_out_valid", out_valid, 0);
        check("ks_key_cnt", key_cnt, 0);
        check("ks_unlocked", unlocked, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // key_start coincident with a key bit during LOAD
        load_key(GOLD, 5);
        key_start = 1'b1; key_bit = 1'b1; key_bit_valid = 1'b1;
        tick();
        key_start = 1'b0; key_bit_valid = 1'b0;
        check("ks_bit_cnt", key_cnt, 0);

        // Partial key: only 19 bits, input must never be accepted
        load_key(GOLD, KEY_W - 1);
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 12; i++) tick();
        check("part_key_cnt", key_cnt, KEY_W - 1);
        check("part_unlocked", unlocked, 0);
        check("part_in_ready", in_ready, 0);
        check("part_out_valid", out_valid, 0);
        in_valid = 1'b0;

        // Random key with random valid/ready traffic
        rkey = KEY_W'($urandom);
        load_key(rkey, KEY_W);
        check("rnd_unlocked", unlocked, 1);
        n0 = n_out;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();
        check("rnd_progress", (n_out - n0) > 100, 1);

        // Full-throughput streaming: in_ready must stay high with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            tick();
            check("thru_accept", last_fin, 1);
        end

        // One-cycle reset while streaming, then reload and verify transform
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_unlocked", unlocked, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_key_cnt", key_cnt, 0);
        for (int i = 0; i < 3; i++) tick();
        load_key(GOLD, KEY_W);
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        tick();
        check("reload_data", out_data, 8'h54);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
